duty_slew: RTL and testbench



---
 rtl/duty_slew.sv | 68 ++++++
 tb/tb_duty_slew.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/duty_slew.sv
// duty_slew: rate-limits a duty request, moving one bounded step toward it
// per synchronised rising edge of the asynchronous update tick.
module duty_slew #(
   parameter int WIDTH       = 16,
   parameter int STEP_MAX    = 256,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] target,
   input  logic             tick,
   input  logic             hold,
   output logic [WIDTH-1:0] value,
   output logic             upd,
   output logic             busy,
   output logic [7:0]       sat_cnt
);
   localparam logic [WIDTH-1:0] STEP   = WIDTH'(STEP_MAX);
   localparam logic [31:0]      STEP_U = 32'(STEP_MAX);
   typedef enum logic [1:0] {IDLE, CALC, APPLY} state_t;
   state_t                 state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist, rise, dir, lim;
   logic [WIDTH-1:0]       tgt_q, diff, abs_diff, step;
   assign rise     = sync_q[SYNC_STAGES-1] & ~hist;
   assign abs_diff = (tgt_q > value) ? tgt_q - value : value - tgt_q;
   assign step     = lim ? STEP : diff;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         sync_q  <= '0;
         hist    <= 1'b0;
         tgt_q   <= '0;
         value   <= '0;
         upd     <= 1'b0;
         busy    <= 1'b0;
         sat_cnt <= '0;
         dir     <= 1'b0;
         diff    <= '0;
         lim     <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], tick};
         hist   <= sync_q[SYNC_STAGES-1];
         busy   <= value != target;
         upd    <= 1'b0;
         case (state)
            IDLE: if (rise && !hold) begin
               tgt_q <= target;
               state <= CALC;
            end
            CALC: begin
               dir   <= tgt_q > value;
               diff  <= abs_diff;
               lim   <= (STEP_MAX != 0) && (32'(abs_diff) > STEP_U);
               state <= APPLY;
            end
            APPLY: begin
               // step never exceeds the distance to tgt_q, so no wrap
               value <= dir ? value + step : value - step;
               upd   <= step != '0;
               if (lim && sat_cnt != 8'hFF) sat_cnt <= sat_cnt + 8'd1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_duty_slew.sv
// tb_duty_slew: table-driven checks of duty_slew plus hand-written corner sequences.
module tb_duty_slew;
   logic        clk = 1'b0;
   logic        rst_n, tick, hold;
   logic [15:0] target, target1, value, value1;
   logic        upd, busy, upd1, busy1;
   logic [7:0]  sat_cnt, sat_cnt1;
   int          checks = 0, failures = 0;
   always #5 clk = ~clk;
   duty_slew #(.WIDTH(16), .STEP_MAX(256), .SYNC_STAGES(2)) u0 (
      .clk(clk), .rst_n(rst_n), .target(target), .tick(tick), .hold(hold),
      .value(value), .upd(upd), .busy(busy), .sat_cnt(sat_cnt));
   duty_slew #(.WIDTH(16), .STEP_MAX(0), .SYNC_STAGES(2)) u1 (
      .clk(clk), .rst_n(rst_n), .target(target1), .tick(tick), .hold(hold),
      .value(value1), .upd(upd1), .busy(busy1), .sat_cnt(sat_cnt1));
   typedef struct {
      logic [15:0] tgt;
      logic        hld;
      logic [15:0] val;
      logic        upd;
      logic [7:0]  sat;
      logic        busy;
   } vec_t;
   vec_t vecs[12];
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask
   // One full tick: value sampled at edge 4 (still old) and edge 5 (new), upd at 5 and 6
   task automatic do_tick(output logic [15:0] v4, output logic [15:0] v5,
                          output logic u5, output logic u6);
      tick = 1'b1;
      repeat (4) cyc();
      v4 = value;
      cyc();
      v5 = value;
      u5 = upd;
      cyc();
      u6 = upd;
      tick = 1'b0;
      repeat (3) cyc();
   endtask
   initial begin
      logic [15:0] v4, v5, prev;
      logic        u5, u6;
      int          pulses;
      vecs[0]  = '{16'h0300, 1'b0, 16'h0100, 1'b1, 8'd1, 1'b1};
      vecs[1]  = '{16'h0300, 1'b0, 16'h0200, 1'b1, 8'd2, 1'b1};
      vecs[2]  = '{16'h0300, 1'b0, 16'h0300, 1'b1, 8'd2, 1'b0};
      vecs[3]  = '{16'h0300, 1'b0, 16'h0300, 1'b0, 8'd2, 1'b0};
      vecs[4]  = '{16'h0050, 1'b0, 16'h0200, 1'b1, 8'd3, 1'b1};
      vecs[5]  = '{16'h0050, 1'b0, 16'h0100, 1'b1, 8'd4, 1'b1};
      vecs[6]  = '{16'h0050, 1'b0, 16'h0050, 1'b1, 8'd4, 1'b0};
      for (int i = 7; i < 12; i++) vecs[i] = '{16'h1000, 1'b1, 16'h0050, 1'b0, 8'd4, 1'b1};
      rst_n = 1'b0; tick = 1'b0; hold = 1'b0; target = 16'h1234; target1 = 16'hFFFF;
      repeat (3) cyc();
      chk("rst_value", 32'(value), 32'h0);
      chk("rst_upd", 32'(upd), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_sat", 32'(sat_cnt), 32'h0);
      rst_n = 1'b1;
      cyc();
      chk("busy_after_release", 32'(busy), 32'h1);
      prev = 16'h0000;
      for (int i = 0; i < 12; i++) begin
         target = vecs[i].tgt;
         hold   = vecs[i].hld;
         do_tick(v4, v5, u5, u6);
         chk($sformatf("v%0d_latency", i), 32'(v4), 32'(prev));
         chk($sformatf("v%0d_value", i), 32'(v5), 32'(vecs[i].val));
         chk($sformatf("v%0d_upd", i), 32'(u5), 32'(vecs[i].upd));
         chk($sformatf("v%0d_upd_clear", i), 32'(u6), 32'h0);
         chk($sformatf("v%0d_sat", i), 32'(sat_cnt), 32'(vecs[i].sat));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
         if (i == 0) begin
            chk("nolimit_value", 32'(value1), 32'hFFFF);
            chk("nolimit_sat", 32'(sat_cnt1), 32'h0);
         end
         prev = vecs[i].val;
      end
      hold = 1'b0;
      // 0x0050 -> 0xFFF0: 255 clipped steps plus one short one; sat_cnt saturates
      target = 16'hFFF0;
      for (int i = 0; i < 256; i++) do_tick(v4, v5, u5, u6);
      chk("ramp_top_value", 32'(value), 32'hFFF0);
      chk("sat_saturated", 32'(sat_cnt), 32'hFF);
      target = 16'hFFFF;
      do_tick(v4, v5, u5, u6);
      chk("top_value", 32'(v5), 32'hFFFF);
      chk("top_upd", 32'(u5), 32'h1);
      chk("top_sat", 32'(sat_cnt), 32'hFF);
      do_tick(v4, v5, u5, u6);
      chk("top_no_wrap", 32'(v5), 32'hFFFF);
      chk("top_no_upd", 32'(u5), 32'h0);
      // second rise lands while the first step is in flight
      target = 16'h0000;
      pulses = 0;
      tick = 1'b1; cyc();
      tick = 1'b0; cyc();
      tick = 1'b1; cyc();
      tick = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         pulses += int'(upd);
      end
      chk("drop_value", 32'(value), 32'hFEFF);
      chk("drop_pulses", 32'(pulses), 32'd1);
      // reset while in APPLY
      tick = 1'b1;
      repeat (4) cyc();
      rst_n = 1'b0;
      tick = 1'b0;
      cyc();
      chk("rst_apply_value", 32'(value), 32'h0);
      chk("rst_apply_upd", 32'(upd), 32'h0);
      chk("rst_apply_sat", 32'(sat_cnt), 32'h0);
      cyc();
      chk("rst_apply_upd_next", 32'(upd), 32'h0);
      rst_n = 1'b1;
      repeat (4) cyc();
      target = 16'h0080;
      do_tick(v4, v5, u5, u6);
      chk("low_up_value", 32'(v5), 32'h0080);
      chk("low_up_sat", 32'(sat_cnt), 32'h0);
      target = 16'h0000;
      do_tick(v4, v5, u5, u6);
      chk("low_latency", 32'(v4), 32'h0080);
      chk("low_value", 32'(v5), 32'h0);
      chk("low_upd", 32'(u5), 32'h1);
      chk("nolimit_final_value", 32'(value1), 32'hFFFF);
      chk("nolimit_final_sat", 32'(sat_cnt1), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
